// File: rtl/fir_decim_out_buffer_pkg.sv
// Shared constants for the FIR output stage: default sample width and buffer geometry,
// plus a small modular-increment helper used by the decimation phase counter.
package fir_decim_out_buffer_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int DEFAULT_DECIM = 4;
    localparam int DEFAULT_SKIP  = 8;
    localparam int DEFAULT_DEPTH = 8;

    function automatic int unsigned wrap_inc(input int unsigned value, input int unsigned modulus);
        if (value + 32'd1 >= modulus) begin
            return 32'd0;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/fir_decim_out_buffer_sync_fifo.sv
// Synchronous FIFO with a registered head word and registered non-empty flag,
// so the read side presents flop outputs only.
module fir_decim_out_buffer_sync_fifo
    import fir_decim_out_buffer_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] head_next;
    logic              not_empty;

    assign full       = (count == CNT_W'(DEPTH));
    assign empty      = !not_empty;
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

    // Next occupancy and next head word; a write into an emptying FIFO becomes the head directly.
    always_comb begin
        count_next = count;
        head_next  = rd_data;
        if (wr_en && !rd_en) begin
            count_next = count + CNT_W'(1);
        end else if (!wr_en && rd_en) begin
            count_next = count - CNT_W'(1);
        end else begin
            count_next = count;
        end
        if (rd_en) begin
            if (count == CNT_W'(1)) begin
                head_next = wr_en ? wr_data : rd_data;
            end else begin
                head_next = mem[rd_ptr_inc];
            end
        end else if (wr_en && (count == CNT_W'(0))) begin
            head_next = wr_data;
        end else begin
            head_next = rd_data;
        end
    end

    // Storage, pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {DATA_W{1'b0}};
            end
            wr_ptr    <= {PTR_W{1'b0}};
            rd_ptr    <= {PTR_W{1'b0}};
            count     <= {CNT_W{1'b0}};
            rd_data   <= {DATA_W{1'b0}};
            not_empty <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr_inc;
            end
            count     <= count_next;
            rd_data   <= head_next;
            not_empty <= (count_next != CNT_W'(0));
        end
    end

endmodule

// File: rtl/fir_decim_out_buffer.sv
// FIR output stage: discards pipeline-fill samples, decimates by DECIM keeping phase 0,
// and buffers kept samples toward a valid/ready sink with a sticky overflow flag.
module fir_decim_out_buffer
    import fir_decim_out_buffer_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int DECIM  = DEFAULT_DECIM,
    parameter int SKIP   = DEFAULT_SKIP,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_sample,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_sample,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   warm,
    output logic                   overflow
);

    localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [SKIP_W-1:0] skip_cnt;
    logic [PH_W-1:0]   phase;
    logic              kept;
    logic              push;
    logic              pop;
    logic              drop;
    logic              full;
    logic              empty;

    // A kept sample may enter a full FIFO only when the head leaves on the same edge.
    always_comb begin
        kept = in_valid && warm && (phase == PH_W'(0));
        pop  = out_valid && out_ready;
        push = kept && (!full || pop);
        drop = kept && full && !pop;
    end

    // Warm-up skip counter, decimation phase and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt <= {SKIP_W{1'b0}};
            phase    <= {PH_W{1'b0}};
            warm     <= (SKIP == 0);
            overflow <= 1'b0;
        end else begin
            if (in_valid) begin
                if (!warm) begin
                    skip_cnt <= skip_cnt + SKIP_W'(1);
                    if (skip_cnt == SKIP_W'(SKIP - 1)) begin
                        warm <= 1'b1;
                    end
                end else begin
                    phase <= PH_W'(wrap_inc(32'(phase), 32'(DECIM)));
                end
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    fir_decim_out_buffer_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (in_sample),
        .rd_en   (pop),
        .rd_data (out_sample),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign out_valid = !empty;

endmodule

// File: tb/tb_fir_decim_out_buffer.sv
// Self-checking bench for fir_decim_out_buffer against a queue-based reference model.
module tb_fir_decim_out_buffer;

    localparam int DW    = 16;
    localparam int DECIM = 4;
    localparam int SKIP  = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_sample;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sample;
    logic [3:0]    fifo_count;
    logic          warm;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: valid samples seen since reset, FIFO contents, sticky overflow.
    logic [DW-1:0] mq[$];
    int            m_vcnt = 0;
    bit            m_ovf  = 1'b0;

    always #5 clk = ~clk;

    fir_decim_out_buffer #(.DATA_W(DW), .DECIM(DECIM), .SKIP(SKIP), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sample  (in_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .fifo_count (fifo_count),
        .warm       (warm),
        .overflow   (overflow)
    );

    function automatic logic [6:0] model_status();
        return {mq.size() != 0, 4'(mq.size()), m_vcnt >= SKIP, m_ovf};
    endfunction

    // Applies one cycle of inputs, advances the model on the edge, returns at the falling edge.
    task automatic drive_cycle(input bit iv, input logic [DW-1:0] s, input bit rdy, input bit r);
        bit kept;
        bit pop;
        rst = r; in_valid = iv; in_sample = s; out_ready = rdy;
        @(posedge clk);
        if (r) begin
            mq.delete(); m_vcnt = 0; m_ovf = 1'b0;
        end else begin
            pop  = (mq.size() != 0) && rdy;
            kept = 1'b0;
            if (iv) begin
                kept = (m_vcnt >= SKIP) && (((m_vcnt - SKIP) % DECIM) == 0);
                m_vcnt++;
            end
            if (pop) mq.delete(0);
            if (kept) begin
                if (mq.size() < DEPTH) mq.push_back(s);
                else m_ovf = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (warm !== 1'b0) begin bad++; $display("FAIL reset_warm got=%b exp=0", warm); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (out_sample !== 16'h0000) begin bad++; $display("FAIL reset_out_sample got=%h exp=0000", out_sample); end
    endtask

    task automatic test_ramp();
        logic [DW-1:0] got[$];
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 1; i <= 44; i++) begin
            total++;
            if ({out_valid, fifo_count, warm, overflow} !== model_status()) begin
                bad++; $display("FAIL ramp_status i=%0d got=%b exp=%b", i, {out_valid, fifo_count, warm, overflow}, model_status());
            end
            if (mq.size() != 0) begin
                total++;
                if (out_sample !== mq[0]) begin bad++; $display("FAIL ramp_data i=%0d got=%h exp=%h", i, out_sample, mq[0]); end
            end
            if (out_valid) got.push_back(out_sample);
            drive_cycle(i <= 40, DW'(i), 1'b1, 1'b0);
        end
        total++;
        if (got.size() != 8) begin
            bad++; $display("FAIL ramp_out_count got=%0d exp=8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (got[k] !== DW'(9 + 4 * k)) begin bad++; $display("FAIL ramp_seq k=%0d got=%0d exp=%0d", k, got[k], 9 + 4 * k); end
            end
        end
    endtask

    task automatic test_full();
        logic [DW-1:0] got[$];
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 1; i <= 48; i++) begin
            total++;
            if ({out_valid, fifo_count, warm, overflow} !== model_status()) begin
                bad++; $display("FAIL full_status i=%0d got=%b exp=%b", i, {out_valid, fifo_count, warm, overflow}, model_status());
            end
            drive_cycle(1'b1, DW'(i), 1'b0, 1'b0);
        end
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", fifo_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_overflow got=%b exp=1", overflow); end
        total++; if (out_sample !== 16'd9) begin bad++; $display("FAIL full_head got=%0d exp=9", out_sample); end
        for (int c = 0; c < 10; c++) begin
            if (out_valid) got.push_back(out_sample);
            drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_drained got=%b exp=0", out_valid); end
        total++;
        if (got.size() != 8) begin
            bad++; $display("FAIL full_out_count got=%0d exp=8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (got[k] !== DW'(9 + 4 * k)) begin bad++; $display("FAIL full_seq k=%0d got=%0d exp=%0d", k, got[k], 9 + 4 * k); end
            end
        end
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] got[$];
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 1; i <= 40; i++) drive_cycle(1'b1, DW'(i), 1'b0, 1'b0);
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL fp_prefill got=%0d exp=8", fifo_count); end
        drive_cycle(1'b1, 16'd41, 1'b1, 1'b0);
        total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL fp_count got=%0d exp=8", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fp_overflow got=%b exp=0", overflow); end
        total++; if (out_sample !== 16'd13) begin bad++; $display("FAIL fp_head got=%0d exp=13", out_sample); end
        for (int c = 0; c < 10; c++) begin
            if (out_valid) got.push_back(out_sample);
            drive_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        total++;
        if (got.size() != 8) begin
            bad++; $display("FAIL fp_out_count got=%0d exp=8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (got[k] !== DW'(13 + 4 * k)) begin bad++; $display("FAIL fp_seq k=%0d got=%0d exp=%0d", k, got[k], 13 + 4 * k); end
            end
        end
    endtask

    task automatic test_toggle();
        logic [DW-1:0] got[$];
        int v = 1;
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 126; c++) begin
            bit iv;
            iv = ((c % 3) == 0) && (v <= 40);
            total++;
            if ({out_valid, fifo_count, warm, overflow} !== model_status()) begin
                bad++; $display("FAIL tog_status c=%0d got=%b exp=%b", c, {out_valid, fifo_count, warm, overflow}, model_status());
            end
            if (out_valid) got.push_back(out_sample);
            drive_cycle(iv, iv ? DW'(v) : DW'($urandom), 1'b1, 1'b0);
            if (iv) v++;
        end
        total++;
        if (got.size() != 8) begin
            bad++; $display("FAIL tog_out_count got=%0d exp=8", got.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                total++;
                if (got[k] !== DW'(9 + 4 * k)) begin bad++; $display("FAIL tog_seq k=%0d got=%0d exp=%0d", k, got[k], 9 + 4 * k); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int outs = 0;
        int i = 1;
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        while (outs < 3 && i <= 60) begin
            if (out_valid) outs++;
            drive_cycle(1'b1, DW'(i), 1'b1, 1'b0);
            i++;
        end
        total++; if (outs != 3) begin bad++; $display("FAIL mid_prerun outputs got=%0d exp=3", outs); end
        drive_cycle(1'b1, 16'd99, 1'b0, 1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
        total++; if (warm !== 1'b0) begin bad++; $display("FAIL mid_warm got=%b exp=0", warm); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
        for (int k = 0; k < SKIP; k++) begin
            total++;
            if (warm !== 1'b0 || fifo_count !== 4'd0) begin
                bad++; $display("FAIL mid_discard k=%0d got warm=%b count=%0d exp warm=0 count=0", k, warm, fifo_count);
            end
            drive_cycle(1'b1, DW'(200 + k), 1'b1, 1'b0);
        end
        total++;
        if (warm !== 1'b1 || fifo_count !== 4'd0) begin
            bad++; $display("FAIL mid_warm_again got warm=%b count=%0d exp warm=1 count=0", warm, fifo_count);
        end
    endtask

    task automatic test_extremes();
        logic [DW-1:0] got[$];
        logic [DW-1:0] vals[12] = '{16'h8000, 16'h1111, 16'h2222, 16'h3333,
                                    16'hFFFF, 16'h4444, 16'h5555, 16'h6666,
                                    16'h7FFF, 16'h0101, 16'h0202, 16'h0303};
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int k = 0; k < SKIP; k++) drive_cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) begin
            if (out_valid) got.push_back(out_sample);
            drive_cycle(k < 12, (k < 12) ? vals[k] : 16'h0000, 1'b1, 1'b0);
        end
        total++;
        if (got.size() != 3) begin
            bad++; $display("FAIL ext_count got=%0d exp=3", got.size());
        end else begin
            total++; if (got[0] !== 16'h8000) begin bad++; $display("FAIL ext_min got=%h exp=8000", got[0]); end
            total++; if (got[1] !== 16'hFFFF) begin bad++; $display("FAIL ext_neg1 got=%h exp=ffff", got[1]); end
            total++; if (got[2] !== 16'h7FFF) begin bad++; $display("FAIL ext_max got=%h exp=7fff", got[2]); end
        end
    endtask

    task automatic test_random();
        drive_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            bit rdy;
            rdy = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            total++;
            if ({out_valid, fifo_count, warm, overflow} !== model_status()) begin
                bad++; $display("FAIL rand_status c=%0d got=%b exp=%b", c, {out_valid, fifo_count, warm, overflow}, model_status());
            end
            if (mq.size() != 0) begin
                total++;
                if (out_sample !== mq[0]) begin bad++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, out_sample, mq[0]); end
            end
            drive_cycle(1'($urandom_range(0, 1)), DW'($urandom), rdy, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sample = 16'h0000; out_ready = 1'b0;
        test_reset();
        test_ramp();
        test_full();
        test_full_pop();
        test_toggle();
        test_reset_mid();
        test_extremes();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
